// File: rtl/cache_rd_arbiter_if.sv
// Read-request channel shared by a cache and the refill bridge.
// The master drives the request side; the slave answers with accept and return data.
interface cache_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int TYPE_W = 3
);
    logic              rd_req;
    logic [TYPE_W-1:0] rd_type;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_data
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_data
    );
endinterface

// File: rtl/cache_rd_arbiter.sv
// Shares the single AXI-bridge refill read port between icache and dcache, one read in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is dcache-wins fixed priority.
module cache_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int TYPE_W = 3
) (
    input  logic                clk_g,
    input  logic                reset,
    cache_rd_arbiter_if.slave   ic,
    cache_rd_arbiter_if.slave   dc,
    cache_rd_arbiter_if.master  mem,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        WAIT  = 3'b100
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;   // 0 = icache, 1 = dcache
    logic   owner_req;
    logic   handshake;
    logic   tie_pick;

    assign owner_req = owner ? dc.rd_req : ic.rd_req;
    assign handshake = (state == GRANT) && owner_req && mem.rd_rdy;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_last set means icache was the last one sent to the bridge, so dcache wins the next tie.
    logic rr_last;

    always_ff @(posedge clk_g) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (handshake) begin
            rr_last <= ~owner;
        end
    end

    assign tie_pick = rr_last;
`else
    assign tie_pick = 1'b1;
`endif

    always_ff @(posedge clk_g) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (ic.rd_req || dc.rd_req) begin
                    state_nxt = GRANT;
                    owner_nxt = (ic.rd_req && dc.rd_req) ? tie_pick : dc.rd_req;
                end
            end
            GRANT: begin
                if (handshake) begin
                    state_nxt = WAIT;
                end else if (!owner_req) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (mem.ret_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Everything is forced low while reset is held, including the data pass-through.
    always_comb begin
        mem.rd_req    = 1'b0;
        mem.rd_type   = '0;
        mem.rd_addr   = '0;
        ic.rd_rdy     = 1'b0;
        dc.rd_rdy     = 1'b0;
        ic.ret_valid  = 1'b0;
        dc.ret_valid  = 1'b0;
        ic.ret_data   = '0;
        dc.ret_data   = '0;
        busy          = 1'b0;
        if (!reset) begin
            ic.ret_data = mem.ret_data;
            dc.ret_data = mem.ret_data;
            busy        = (state != IDLE);
            if (state == GRANT) begin
                mem.rd_req  = owner_req;
                mem.rd_type = owner ? dc.rd_type : ic.rd_type;
                mem.rd_addr = owner ? dc.rd_addr : ic.rd_addr;
                ic.rd_rdy   = !owner && ic.rd_req && mem.rd_rdy;
                dc.rd_rdy   =  owner && dc.rd_req && mem.rd_rdy;
            end
            if (state == WAIT) begin
                ic.ret_valid = !owner && mem.ret_valid;
                dc.ret_valid =  owner && mem.ret_valid;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: directed cycle tables, then random traffic against a transaction model.
module tb_cache_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int TYPE_W = 3;

    localparam logic [ADDR_W-1:0] IC_A = 32'h1FC0_0000;
    localparam logic [ADDR_W-1:0] DC_A = 32'h8000_1240;
    localparam logic [TYPE_W-1:0] T_LINE = 3'b100;
    localparam logic [TYPE_W-1:0] T_WORD = 3'b010;

    // Output vector order: {mem_rd_req, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, busy}
    localparam bit [5:0] MQ = 6'b100000;
    localparam bit [5:0] IR = 6'b010000;
    localparam bit [5:0] DR = 6'b001000;
    localparam bit [5:0] IV = 6'b000100;
    localparam bit [5:0] DV = 6'b000010;
    localparam bit [5:0] B  = 6'b000001;

    logic clk_g = 1'b0;
    logic reset;
    logic busy;

    always #5 clk_g = ~clk_g;

    cache_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) ic_if ();
    cache_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) dc_if ();
    cache_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) mem_if ();

    cache_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) dut (
        .clk_g (clk_g),
        .reset (reset),
        .ic    (ic_if),
        .dc    (dc_if),
        .mem   (mem_if),
        .busy  (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit       rst;
        bit       icr;
        bit       dcr;
        bit       rdy;
        bit       rv;
        bit [5:0] exp;
        bit       sel;   // 1: dcache address expected on the bridge
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit icr, input bit dcr, input bit rdy,
                                input bit rv, input bit [5:0] exp, input bit sel);
        vec_t v;
        v.rst = rst; v.icr = icr; v.dcr = dcr; v.rdy = rdy; v.rv = rv; v.exp = exp; v.sel = sel;
        vecs.push_back(v);
    endfunction

    function automatic logic [5:0] obs();
        return {mem_if.rd_req, ic_if.rd_rdy, dc_if.rd_rdy, ic_if.ret_valid, dc_if.ret_valid, busy};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [DATA_W-1:0] d;
        @(negedge clk_g);
        d = {$urandom, $urandom, $urandom, $urandom};
        reset            = v.rst;
        ic_if.rd_req     = v.icr;
        ic_if.rd_type    = T_LINE;
        ic_if.rd_addr    = IC_A;
        dc_if.rd_req     = v.dcr;
        dc_if.rd_type    = T_WORD;
        dc_if.rd_addr    = DC_A;
        mem_if.rd_rdy    = v.rdy;
        mem_if.ret_valid = v.rv;
        mem_if.ret_data  = d;
        #1;
        check($sformatf("vec%0d outputs", idx), obs(), v.exp);
        check($sformatf("vec%0d ic_ret_data", idx), ic_if.ret_data, v.rst ? '0 : d);
        check($sformatf("vec%0d dc_ret_data", idx), dc_if.ret_data, v.rst ? '0 : d);
        if (v.exp[5]) begin
            check($sformatf("vec%0d mem_rd_addr", idx), mem_if.rd_addr, v.sel ? DC_A : IC_A);
            check($sformatf("vec%0d mem_rd_type", idx), mem_if.rd_type, v.sel ? T_WORD : T_LINE);
        end
    endtask

    // Random-phase model state: which cache holds the port and whether its read went out.
    int          holder;
    bit          sent;
    bit          rr_ic_last;
    bit          ic_pend, ic_wait, dc_pend, dc_wait;
    bit          rst_r, rdy_r, rv_r;
    bit [1:0]    req;
    bit [5:0]    e;
    logic [DATA_W-1:0] d_r;

    initial begin
        reset            = 1'b1;
        ic_if.rd_req     = 1'b0;
        ic_if.rd_type    = '0;
        ic_if.rd_addr    = '0;
        dc_if.rd_req     = 1'b0;
        dc_if.rd_type    = '0;
        dc_if.rd_addr    = '0;
        mem_if.rd_rdy    = 1'b0;
        mem_if.ret_valid = 1'b0;
        mem_if.ret_data  = '0;

        // reset held with every input active, then quiet idle
        add(1, 1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // icache alone; stray return in GRANT and bridge-ready in WAIT are ignored
        add(0, 1, 0, 0, 0, 0,            0);
        add(0, 1, 0, 0, 1, MQ | B,       0);
        add(0, 1, 0, 0, 0, MQ | B,       0);
        add(0, 1, 0, 1, 0, MQ | IR | B,  0);
        add(0, 0, 0, 1, 0, B,            0);
        add(0, 0, 0, 0, 0, B,            0);
        add(0, 0, 0, 0, 1, IV | B,       0);
        add(0, 0, 0, 0, 0, 0,            0);
        // stray return and bridge-ready in IDLE
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        // dcache with the bridge stalling for 10 cycles
        add(0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, MQ | B, 1);
        add(0, 0, 1, 1, 0, MQ | DR | B, 1);
        add(0, 0, 0, 0, 1, DV | B,      1);
        add(0, 0, 0, 0, 0, 0,           0);
        // owner withdraws in GRANT: no handshake, back to IDLE
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, B, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        // reset while a read is outstanding, then a late return
        add(0, 1, 0, 0, 0, 0,           0);
        add(0, 1, 0, 1, 0, MQ | IR | B, 0);
        add(1, 0, 0, 0, 0, 0,           0);
        add(0, 0, 0, 0, 1, 0,           0);
        add(0, 0, 0, 0, 0, 0,           0);
        // simultaneous requests from a fresh reset
        add(1, 0, 0, 0, 0, 0, 0);
`ifdef ARB_ROUND_ROBIN_EN
        add(0, 1, 1, 0, 0, 0,           0);
        add(0, 1, 1, 1, 0, MQ | IR | B, 0);
        add(0, 1, 1, 0, 1, IV | B,      0);
        add(0, 1, 1, 0, 0, 0,           0);
        add(0, 1, 1, 1, 0, MQ | DR | B, 1);
        add(0, 1, 1, 0, 1, DV | B,      0);
        add(0, 1, 1, 0, 0, 0,           0);
        add(0, 1, 1, 1, 0, MQ | IR | B, 0);
        add(0, 1, 1, 0, 1, IV | B,      0);
        add(0, 1, 1, 0, 0, 0,           0);
        add(0, 1, 1, 1, 0, MQ | DR | B, 1);
        add(0, 0, 0, 0, 1, DV | B,      0);
        add(0, 0, 0, 0, 0, 0,           0);
`else
        add(0, 1, 1, 0, 0, 0,           0);
        add(0, 1, 1, 1, 0, MQ | DR | B, 1);
        add(0, 1, 0, 0, 1, DV | B,      0);
        add(0, 1, 0, 0, 0, 0,           0);
        add(0, 1, 0, 1, 0, MQ | IR | B, 0);
        add(0, 0, 0, 0, 1, IV | B,      0);
        add(0, 0, 0, 0, 0, 0,           0);
`endif

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

        // Random traffic: caches obey the hold-until-accepted contract, bridge behaves arbitrarily.
        holder = -1; sent = 0; rr_ic_last = 0;
        ic_pend = 0; ic_wait = 0; dc_pend = 0; dc_wait = 0;
        @(negedge clk_g);
        reset = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_g);
            rst_r = ($urandom_range(149) == 0);
            if (!ic_pend && !ic_wait && $urandom_range(2) == 0) begin
                ic_pend       = 1;
                ic_if.rd_addr = $urandom;
                ic_if.rd_type = $urandom_range(1) ? T_LINE : T_WORD;
            end
            if (!dc_pend && !dc_wait && $urandom_range(2) == 0) begin
                dc_pend       = 1;
                dc_if.rd_addr = $urandom;
                dc_if.rd_type = $urandom_range(1) ? T_LINE : T_WORD;
            end
            rdy_r = $urandom_range(1);
            rv_r  = ($urandom_range(3) == 0);
            d_r   = {$urandom, $urandom, $urandom, $urandom};
            reset            = rst_r;
            ic_if.rd_req     = ic_pend;
            dc_if.rd_req     = dc_pend;
            mem_if.rd_rdy    = rdy_r;
            mem_if.ret_valid = rv_r;
            mem_if.ret_data  = d_r;
            #1;
            req = {dc_pend, ic_pend};
            e = 0;
            if (!rst_r && holder >= 0) begin
                e |= B;
                if (!sent) begin
                    if (req[holder]) e |= MQ;
                    if (req[holder] && rdy_r) e |= (holder == 0) ? IR : DR;
                end else if (rv_r) begin
                    e |= (holder == 0) ? IV : DV;
                end
            end
            check($sformatf("rnd%0d outputs", c), obs(), e);
            check($sformatf("rnd%0d ret_data", c), ic_if.ret_data, rst_r ? '0 : d_r);
            if (e[5]) begin
                check($sformatf("rnd%0d mem_rd_addr", c), mem_if.rd_addr,
                      (holder == 0) ? ic_if.rd_addr : dc_if.rd_addr);
                check($sformatf("rnd%0d mem_rd_type", c), mem_if.rd_type,
                      (holder == 0) ? ic_if.rd_type : dc_if.rd_type);
            end
            if (rst_r) begin
                holder = -1; sent = 0; rr_ic_last = 0;
                ic_pend = 0; ic_wait = 0; dc_pend = 0; dc_wait = 0;
            end else begin
                if (holder < 0) begin
                    if (ic_pend && dc_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                        holder = rr_ic_last ? 1 : 0;
`else
                        holder = 1;
`endif
                    end else if (ic_pend || dc_pend) begin
                        holder = dc_pend ? 1 : 0;
                    end
                end else if (!sent) begin
                    if (req[holder] && rdy_r) begin
                        sent       = 1;
                        rr_ic_last = (holder == 0);
                    end else if (!req[holder]) begin
                        holder = -1;
                    end
                end else if (rv_r) begin
                    holder = -1;
                    sent   = 0;
                end
                if (e[4]) begin ic_pend = 0; ic_wait = 1; end
                if (e[3]) begin dc_pend = 0; dc_wait = 1; end
                if (e[2]) ic_wait = 0;
                if (e[1]) dc_wait = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
